// File: rtl/cpu_clock_ctrl_if.sv
// rtl/cpu_clock_ctrl_if.sv - run-control signal bundle between board I/O and cpu_clock_ctrl
//
// Purpose : groups the switch/key/halt inputs and the CPU enable, reset, LED
//           and state outputs of the run-control block.
// Modports: master - board/bench side, drives swModo, btStep_n, halt
//           slave  - cpu_clock_ctrl side, drives cpuEn, cpuRst, ledClk,
//                    ledStep, state (and stepCount when STEP_COUNT_EN)
// Macro   : STEP_COUNT_EN adds the 8-bit stepCount signal.
interface cpu_clock_ctrl_if;
    logic       swModo;
    logic       btStep_n;
    logic       halt;
    logic       cpuEn;
    logic       cpuRst;
    logic       ledClk;
    logic       ledStep;
    logic [1:0] state;
`ifdef STEP_COUNT_EN
    logic [7:0] stepCount;

    modport master (
        output swModo, btStep_n, halt,
        input  cpuEn, cpuRst, ledClk, ledStep, state, stepCount
    );
    modport slave (
        input  swModo, btStep_n, halt,
        output cpuEn, cpuRst, ledClk, ledStep, state, stepCount
    );
`else
    modport master (
        output swModo, btStep_n, halt,
        input  cpuEn, cpuRst, ledClk, ledStep, state
    );
    modport slave (
        input  swModo, btStep_n, halt,
        output cpuEn, cpuRst, ledClk, ledStep, state
    );
`endif
endinterface

// File: rtl/cpu_clock_ctrl.sv
// rtl/cpu_clock_ctrl.sv - single-clock run controller producing the Nano CPU clock enable
//
// Purpose : generates a one-cycle cpuEn pulse either from a divided tick
//           (AUTO) or from one debounced step-key press (STEP), sequences the
//           CPU reset and parks the CPU on a halt request.
// Ports   : CLK_28   - 28 MHz system clock, the only clock
//           btRst    - synchronous active-low reset
//           bus      - cpu_clock_ctrl_if.slave:
//                      swModo (0 AUTO / 1 STEP), btStep_n (raw key, active-low),
//                      halt, cpuEn, cpuRst, ledClk, ledStep, state[1:0]
//                      (0 RST_HOLD, 1 RUN, 2 STEP_WAIT, 3 HALTED)
// Macro   : STEP_COUNT_EN adds bus.stepCount[7:0], a wrapping count of cpuEn pulses.
module cpu_clock_ctrl #(
    parameter int DIV        = 14000000,
    parameter int DEB_CYCLES = 280000,
    parameter int RST_CYCLES = 4
) (
    input  logic             CLK_28,
    input  logic             btRst,
    cpu_clock_ctrl_if.slave  bus
);
    localparam int DIV_W  = $clog2(DIV);
    localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
    localparam int HOLD_W = $clog2(RST_CYCLES + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RST_HOLD  = 2'd0,
        ST_RUN       = 2'd1,
        ST_STEP_WAIT = 2'd2,
        ST_HALTED    = 2'd3
    } state_t;

    logic              key_s1_q, key_s1_d, key_s2_q, key_s2_d;
    logic              mode_s1_q, mode_s1_d, mode_s2_q, mode_s2_d;
    logic              deb_level_q, deb_level_d;
    logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic              press_q, press_d;
    logic              armed_q, armed_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic              led_clk_q, led_clk_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    state_t            state_q, state_d;
    logic              cpu_en_q, cpu_en_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              key_pressed;
    logic              tick;
`ifdef STEP_COUNT_EN
    logic [7:0]        step_cnt_q, step_cnt_d;
`endif

    always_comb begin
        key_s1_d    = bus.btStep_n;
        key_s2_d    = key_s1_q;
        mode_s1_d   = bus.swModo;
        mode_s2_d   = mode_s1_q;
        deb_level_d = deb_level_q;
        deb_cnt_d   = deb_cnt_q;
        press_d     = 1'b0;
        state_d     = state_q;
        cpu_en_d    = 1'b0;
        hold_cnt_d  = hold_cnt_q;

        // Debounce: a new level is accepted after DEB_CYCLES consecutive
        // differing samples; any agreeing sample restarts the count.
        key_pressed = ~key_s2_q;
        if (key_pressed != deb_level_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                deb_level_d = key_pressed;
                deb_cnt_d   = '0;
                press_d     = key_pressed & armed_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end else begin
            deb_cnt_d = '0;
        end

        // A press only counts once the key has been seen released outside
        // RST_HOLD, so a key held across reset cannot fire a step.
        armed_d = armed_q | (key_s1_q & key_s2_q & ~deb_level_q &
                             (state_q != ST_RST_HOLD));

        tick      = (state_q == ST_RUN) && (div_cnt_q == DIV_LAST);
        led_clk_d = led_clk_q ^ tick;

        case (state_q)
            ST_RST_HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    hold_cnt_d = '0;
                    state_d    = mode_s2_q ? ST_STEP_WAIT : ST_RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (bus.halt)
                    state_d = ST_HALTED;
                else if (mode_s2_q)
                    state_d = ST_STEP_WAIT;
                else
                    cpu_en_d = tick;
            end
            ST_STEP_WAIT: begin
                if (bus.halt)
                    state_d = ST_HALTED;
                else if (!mode_s2_q)
                    state_d = ST_RUN;
                else
                    cpu_en_d = press_q;
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
        endcase

        // The divider only advances while staying in RUN, so every entry
        // into RUN starts from zero.
        if ((state_q == ST_RUN) && (state_d == ST_RUN))
            div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
        else
            div_cnt_d = '0;

        cpu_rst_d = (state_d == ST_RST_HOLD);
`ifdef STEP_COUNT_EN
        step_cnt_d = step_cnt_q + {7'd0, cpu_en_d};
`endif
    end

    always_ff @(posedge CLK_28) begin
        if (!btRst) begin
            key_s1_q    <= 1'b1;
            key_s2_q    <= 1'b1;
            mode_s1_q   <= 1'b1;
            mode_s2_q   <= 1'b1;
            deb_level_q <= 1'b0;
            deb_cnt_q   <= '0;
            press_q     <= 1'b0;
            armed_q     <= 1'b0;
            div_cnt_q   <= '0;
            led_clk_q   <= 1'b0;
            hold_cnt_q  <= '0;
            state_q     <= ST_RST_HOLD;
            cpu_en_q    <= 1'b0;
            cpu_rst_q   <= 1'b1;
`ifdef STEP_COUNT_EN
            step_cnt_q  <= 8'd0;
`endif
        end else begin
            key_s1_q    <= key_s1_d;
            key_s2_q    <= key_s2_d;
            mode_s1_q   <= mode_s1_d;
            mode_s2_q   <= mode_s2_d;
            deb_level_q <= deb_level_d;
            deb_cnt_q   <= deb_cnt_d;
            press_q     <= press_d;
            armed_q     <= armed_d;
            div_cnt_q   <= div_cnt_d;
            led_clk_q   <= led_clk_d;
            hold_cnt_q  <= hold_cnt_d;
            state_q     <= state_d;
            cpu_en_q    <= cpu_en_d;
            cpu_rst_q   <= cpu_rst_d;
`ifdef STEP_COUNT_EN
            step_cnt_q  <= step_cnt_d;
`endif
        end
    end

    assign bus.cpuEn   = cpu_en_q;
    assign bus.cpuRst  = cpu_rst_q;
    assign bus.ledClk  = led_clk_q;
    assign bus.ledStep = deb_level_q;
    assign bus.state   = state_q;
`ifdef STEP_COUNT_EN
    assign bus.stepCount = step_cnt_q;
`endif
endmodule

// File: doc/cpu_clock_ctrl.md
Name: cpu_clock_ctrl

Overview:
Run-control block for the Nano CPU on the DE2 board. Replaces the raw clock mux between the divided clock and the step key with a single-clock-domain controller on CLK_28. It drives a one-cycle clock-enable pulse, cpuEn, in AUTO mode (divided tick) or STEP mode (one debounced press, one pulse). It also sequences CPU reset and stops the CPU on a halt request.

Parameters:
DIV, 14000000, CLK_28 cycles per AUTO tick (≥2); default gives 2 Hz
DEB_CYCLES, 280000, consecutive stable samples needed to accept a key level (≥1); default is 10 ms
RST_CYCLES, 4, cycles cpuRst is held after btRst releases (≥1)

Ports:
CLK_28  input  1  system clock, 28 MHz, the only clock
btRst  input  1  reset, synchronous, active-low
swModo  input  1  0 = AUTO, 1 = STEP; static switch, synchronised internally
btStep_n  input  1  raw step key, active-low, asynchronous, bouncing
halt  input  1  CPU halt request, synchronous to CLK_28
cpuEn  output  1  one-cycle clock enable for the CPU
cpuRst  output  1  active-high CPU reset
ledClk  output  1  toggles on every AUTO tick (LEDG[0])
ledStep  output  1  debounced key level, 1 = pressed (LEDG[1])
state  output  2  FSM state: 0 RST_HOLD, 1 RUN, 2 STEP_WAIT, 3 HALTED

Behaviour:
- Reset (btRst=0 at a CLK_28 edge):
  - state=RST_HOLD; cpuRst=1; cpuEn=0; ledClk=0; ledStep=0.
  - Divider count, debounce count and hold count cleared to 0.
  - Debounced key level = released; synchroniser flops = 1 (released).
  - Reset mid-operation has the same effect, whatever the state.
- Synchronisers:
  - btStep_n and swModo each pass through 2 flops before use.
- Debounce:
  - The counter increments while the synchronised key differs from the debounced level.
  - It clears to 0 whenever they match.
  - When the count reaches DEB_CYCLES-1 with a difference still present, the debounced level flips and the counter clears.
  - ledStep = debounced level.
  - press = one-cycle pulse on the debounced released→pressed transition. A key held down gives exactly one press.
- Divider:
  - Counts 0..DIV-1 and wraps to 0.
  - tick=1 in the cycle the count equals DIV-1.
  - ledClk toggles on each tick.
  - The divider runs only in RUN. It is cleared to 0 on entry to RUN.
- FSM (registered outputs, one cycle after the decision edge):
  - RST_HOLD: cpuRst=1, cpuEn=0.
    - After RST_CYCLES cycles with btRst=1, goes to RUN if swModo_sync=0, else STEP_WAIT.
    - cpuRst drops in the same cycle as the state change.
    - press events during RST_HOLD are discarded.
  - RUN: cpuEn=tick, delayed one cycle by the output register.
    - halt=1 → HALTED; priority over a coincident tick, so no pulse is emitted.
    - else swModo_sync=1 → STEP_WAIT; a coincident tick is dropped.
  - STEP_WAIT: cpuEn=1 for exactly one cycle per press.
    - halt=1 → HALTED; a coincident press is dropped.
    - else swModo_sync=0 → RUN; a coincident press is dropped.
  - HALTED: cpuEn=0, cpuRst=0.
    - Ignores ticks, presses and swModo.
    - Exits only via btRst.
- cpuEn is never high for two consecutive cycles.
- cpuEn and cpuRst are never high together.

Optional Feature:
STEP_COUNT_EN:
- Defined:
  - Adds output port stepCount[7:0]. It counts cpuEn pulses since reset (reset value 0) and wraps 255→0.
  - The intended use is HEX display of executed instruction count.
- Undefined:
  - The port and counter are absent. All other behaviour is identical.

Test Plan:
Use DIV=4, DEB_CYCLES=3, RST_CYCLES=4 throughout.
1. Reset and AUTO run: btRst=0 for 2 cycles, then 1, with swModo=0.
   - cpuRst=1 for 4 cycles after release, then state=1.
   - cpuEn pulses every 4th cycle, never two in a row.
   - ledClk toggles on each tick.
2. Step and debounce: swModo=1; btStep_n toggles every cycle for 10 cycles, then is held at 0 for 20 cycles.
   - No pulse during the bounce.
   - Exactly one cpuEn pulse 2 (sync) + 3 (debounce) + 1 cycles after the stable 0 begins.
   - Releasing and pressing again gives a second pulse.
3. Halt priority: in RUN, assert halt in the same cycle the divider equals 3.
   - No cpuEn; state=3.
   - Further presses and swModo changes give no cpuEn until btRst=0.
4. Mode switch: change swModo 0→1 mid-divide.
   - state=2 after 3 cycles; no cpuEn from the old tick schedule.
   - Switching back to 0 restarts the divider from 0, so the first pulse comes 4 cycles after entering RUN.
5. Reset mid-operation: assert btRst=0 in STEP_WAIT while the key is held, then release btRst.
   - cpuRst=1 for 4 cycles after release, with no cpuEn during the hold.
   - The held key does not produce a pulse after reset until it is released and pressed again.
6. STEP_COUNT_EN defined: apply 257 steps.
   - stepCount=1 (wrapped).
   - btRst=0 clears it to 0.
